io_axil_uart_regs: RTL and testbench

- AXI4-Lite slave that sits directly downstream of the core's IN/OUT port, at the other end of the AR/R/AW/W/B channels.
- Implements the UART-Lite style register map the core polls:
  - 0x0 RX FIFO
  - 0x4 TX FIFO
  - 0x8 STAT
  - 0xC CTRL
- Buffers bytes in RX and TX FIFOs and exposes byte streams to a separate serial PHY.

---
 rtl/io_uart_pkg.sv | 29 ++
 rtl/io_axil_uart_regs_if.sv | 30 +++
 rtl/io_byte_fifo.sv | 44 ++++
 rtl/io_axil_uart_regs.sv | 178 +++++++++++++++++
 tb/tb_io_axil_uart_regs.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - shared constants, read-FSM states and decode helper for the AXI-Lite UART register block
package io_uart_pkg;

  localparam logic [3:0] ADDR_RX   = 4'h0;
  localparam logic [3:0] ADDR_TX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'hC;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;
  localparam int STAT_OVERRUN  = 5;

  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_INTR_EN  = 4;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic {R_IDLE, R_RESP} rd_state_e;

  // Registers are word-aligned: only address bits [3:2] select a register.
  function automatic logic [1:0] reg_idx(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/io_axil_uart_regs_if.sv
// rtl/io_axil_uart_regs_if.sv - AXI4-Lite AR/R/AW/W/B channel bundle with master and slave views
interface io_axil_uart_regs_if #(parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/io_byte_fifo.sv
// rtl/io_byte_fifo.sv - synchronous 8-bit FIFO with push/pop/flush and MSB-extended pointers
module io_byte_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q[PW-1:0]] <= din_i;
  end
endmodule

// File: rtl/io_axil_uart_regs.sv
// rtl/io_axil_uart_regs.sv - AXI4-Lite UART-Lite register block with RX/TX byte FIFOs and interrupt pulse
module io_axil_uart_regs
  import io_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  io_axil_uart_regs_if.slave  axil,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic                intr_o
);
  rd_state_e   r_state_q, r_state_d;
  logic        ready_en_q;
  logic [31:0] rdata_q, rdata_d, stat;
  logic [1:0]  rsel_q, wsel_q;
  logic        rd_pop_q, ar_hs, r_hs;
  logic        aw_held_q, w_held_q, bvalid_q, wstrb0_q;
  logic [7:0]  wdata_q;
  logic        aw_hs, w_hs, wr_exec, ctrl_wr;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]  rx_head;
  logic        rx_push, rx_pop, rx_flush, tx_push, tx_pop, tx_flush, overrun_set;
  logic        overrun_q, intr_en_q, intr_q, rx_empty_q, tx_empty_q, tx_flush_q;

  always_comb begin
    stat                = '0;
    stat[STAT_RX_VALID] = ~rx_empty;
    stat[STAT_RX_FULL]  = rx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_TX_FULL]  = tx_full;
    stat[STAT_INTR_EN]  = intr_en_q;
    stat[STAT_OVERRUN]  = overrun_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state_q <= R_IDLE;
    else         r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    ar_hs     = 1'b0;
    r_hs      = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (axil.arvalid && ready_en_q) begin
          ar_hs     = 1'b1;
          r_state_d = R_RESP;
          if (reg_idx(axil.araddr[3:0]) == reg_idx(ADDR_RX))
            rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
          else if (reg_idx(axil.araddr[3:0]) == reg_idx(ADDR_STAT))
            rdata_d = stat;
          else
            rdata_d = 32'h0;
        end
      end
      R_RESP: begin
        if (axil.rready) begin
          r_hs      = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign axil.arready = ready_en_q & (r_state_q == R_IDLE);
  assign axil.rvalid  = (r_state_q == R_RESP);
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = AXI_RESP_OKAY;

  assign axil.awready = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign axil.wready  = ready_en_q & ~w_held_q & ~bvalid_q;
  assign axil.bvalid  = bvalid_q;
  assign axil.bresp   = AXI_RESP_OKAY;

  assign aw_hs    = axil.awvalid & axil.awready;
  assign w_hs     = axil.wvalid & axil.wready;
  assign wr_exec  = aw_held_q & w_held_q;
  assign ctrl_wr  = wr_exec & (wsel_q == reg_idx(ADDR_CTRL));
  assign tx_push  = wr_exec & (wsel_q == reg_idx(ADDR_TX)) & wstrb0_q;
  assign tx_flush = ctrl_wr & wdata_q[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & wdata_q[CTRL_RX_FLUSH];
  assign tx_pop   = tx_valid_o & tx_ready_i;

  // The CPU's pop frees a slot in the same cycle, so a byte arriving then is not an overrun.
  assign rx_pop      = r_hs & rd_pop_q;
  assign rx_push     = rx_valid_i & (~rx_full | rx_pop);
  assign overrun_set = rx_valid_i & rx_full & ~rx_pop;

  assign tx_valid_o = ~tx_empty;
  assign intr_o     = intr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_en_q <= 1'b0;
      rdata_q    <= '0;
      rsel_q     <= '0;
      rd_pop_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      wsel_q     <= '0;
      wdata_q    <= '0;
      wstrb0_q   <= 1'b0;
      overrun_q  <= 1'b0;
      intr_en_q  <= 1'b0;
      intr_q     <= 1'b0;
      rx_empty_q <= 1'b1;
      tx_empty_q <= 1'b1;
      tx_flush_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      rdata_q    <= rdata_d;
      if (ar_hs) begin
        rsel_q   <= reg_idx(axil.araddr[3:0]);
        rd_pop_q <= (reg_idx(axil.araddr[3:0]) == reg_idx(ADDR_RX)) & ~rx_empty;
      end
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        wsel_q    <= reg_idx(axil.awaddr[3:0]);
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= axil.wdata[7:0];
        wstrb0_q <= axil.wstrb[0];
      end
      if (wr_exec) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
      end else if (bvalid_q && axil.bready) begin
        bvalid_q <= 1'b0;
      end
      if (overrun_set)
        overrun_q <= 1'b1;
      else if (r_hs && rsel_q == reg_idx(ADDR_STAT))
        overrun_q <= 1'b0;
      if (ctrl_wr) intr_en_q <= wdata_q[CTRL_INTR_EN];
      // A tx_empty rise one cycle after a flush came from that flush and stays silent.
      intr_q     <= intr_en_q & ((rx_empty_q & ~rx_empty) | (~tx_empty_q & tx_empty & ~tx_flush_q));
      rx_empty_q <= rx_empty;
      tx_empty_q <= tx_empty;
      tx_flush_q <= tx_flush;
    end
  end

  io_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_push),
    .din_i   (rx_data_i),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  io_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_push),
    .din_i   (wdata_q),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .dout_o  (tx_data_o),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );
endmodule

// File: tb/tb_io_axil_uart_regs.sv
// tb/tb_io_axil_uart_regs.sv - scoreboard bench for the AXI-Lite UART register block
module tb_io_axil_uart_regs;
  import io_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, intr;
  int         total = 0;
  int         bad = 0;
  int         intr_cnt = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_model[$];
  logic [7:0]  rx_model[$];

  always #5 clk = ~clk;

  io_axil_uart_regs_if #(.ADDR_W(4)) axil();

  io_axil_uart_regs #(.FIFO_DEPTH(16), .ADDR_W(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .axil       (axil),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .intr_o     (intr)
  );

  always @(negedge clk) if (intr === 1'b1) intr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: AW and W together, 1: W before AW, 2: AW before W
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input int mode);
    logic aw_go, w_go;
    int   n;
    axil.awaddr = addr;
    axil.wdata  = data;
    axil.wstrb  = 4'hF;
    axil.wvalid  = (mode != 2);
    axil.awvalid = (mode != 1);
    for (int c = 0; c < 20 && (axil.awvalid || axil.wvalid); c++) begin
      aw_go = axil.awvalid && axil.awready;
      w_go  = axil.wvalid && axil.wready;
      tick();
      if (aw_go) begin axil.awvalid = 1'b0; if (mode == 2) axil.wvalid = 1'b1; end
      if (w_go)  begin axil.wvalid = 1'b0;  if (mode == 1) axil.awvalid = 1'b1; end
    end
    total++;
    if (axil.awvalid || axil.wvalid) begin
      bad++;
      $display("FAIL wr_accept addr=%h awvalid=%b wvalid=%b required both accepted", addr, axil.awvalid, axil.wvalid);
      axil.awvalid = 1'b0;
      axil.wvalid  = 1'b0;
    end
    axil.bready = 1'b1;
    n = 0;
    while (axil.bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    total++;
    if (axil.bvalid !== 1'b1 || axil.bresp !== 2'b00) begin
      bad++;
      $display("FAIL wr_bresp addr=%h bvalid=%b bresp=%b required 1/00", addr, axil.bvalid, axil.bresp);
    end
    tick();
    axil.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string name,
                          input logic strobe, input logic [7:0] sdata);
    logic [31:0] got, e;
    int n;
    exp_q.push_back(exp);
    axil.araddr  = addr;
    axil.arvalid = 1'b1;
    n = 0;
    while (axil.arready !== 1'b1 && n < 20) begin tick(); n++; end
    total++;
    if (axil.arready !== 1'b1 || axil.rvalid !== 1'b0) begin
      bad++;
      $display("FAIL %s_ar arready=%b rvalid=%b required 1/0", name, axil.arready, axil.rvalid);
    end
    tick();
    axil.arvalid = 1'b0;
    total++;
    if (axil.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL %s_rvalid_latency rvalid=%b required 1", name, axil.rvalid);
    end
    got = axil.rdata;
    tick();
    total++;
    if (axil.rvalid !== 1'b1 || axil.rdata !== got) begin
      bad++;
      $display("FAIL %s_hold rvalid=%b rdata=%h required 1/%h", name, axil.rvalid, axil.rdata, got);
    end
    e = exp_q.pop_front();
    total++;
    if (axil.rdata !== e || axil.rresp !== 2'b00) begin
      bad++;
      $display("FAIL %s rdata=%h rresp=%b required %h/00", name, axil.rdata, axil.rresp, e);
    end
    axil.rready = 1'b1;
    if (strobe) begin rx_data = sdata; rx_valid = 1'b1; end
    tick();
    axil.rready = 1'b0;
    rx_valid    = 1'b0;
  endtask

  task automatic rx_strobe(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    if (rx_model.size() < 16) rx_model.push_back(d);
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] rx_expect();
    if (rx_model.size() == 0) return 32'h0;
    return {24'h0, rx_model.pop_front()};
  endfunction

  task automatic test_reset();
    axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
    axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0;
    axil.wvalid = 1'b0; axil.bready = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({axil.arready, axil.awready, axil.wready, axil.rvalid, axil.bvalid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_handshake ar/aw/w/r/b=%b required 00000",
               {axil.arready, axil.awready, axil.wready, axil.rvalid, axil.bvalid});
    end
    total++;
    if (axil.rdata !== 32'h0 || tx_valid !== 1'b0 || intr !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs rdata=%h tx_valid=%b intr=%b required 0/0/0", axil.rdata, tx_valid, intr);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    axi_read(ADDR_STAT, 32'h4, "stat_after_reset", 1'b0, 8'h0);
  endtask

  task automatic test_tx_same_cycle();
    axi_write(ADDR_TX, 32'h41, 0);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      bad++;
      $display("FAIL tx_single tx_valid=%b tx_data=%h required 1/41", tx_valid, tx_data);
    end
    axi_read(ADDR_STAT, 32'h0, "stat_tx_one", 1'b0, 8'h0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    total++;
    if (tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL tx_pop tx_valid=%b required 0", tx_valid);
    end
  endtask

  task automatic test_tx_full();
    int n;
    for (int i = 0; i < 17; i++) begin
      axi_write(ADDR_TX, 32'(i), (i == 16) ? 1 : ((i == 3) ? 2 : 0));
      if (tx_model.size() < 16) tx_model.push_back(8'(i));
      if (i == 15) axi_read(ADDR_STAT, 32'h8, "stat_tx_full", 1'b0, 8'h0);
    end
    axi_read(ADDR_STAT, 32'h8, "stat_tx_full_after_drop", 1'b0, 8'h0);
    tx_ready = 1'b1;
    n = 0;
    while (tx_valid === 1'b1 && n < 40) begin
      total++;
      if (tx_model.size() == 0 || tx_data !== tx_model[0]) begin
        bad++;
        $display("FAIL tx_drain tx_data=%h required %h", tx_data, (tx_model.size() != 0) ? tx_model[0] : 8'hxx);
      end
      if (tx_model.size() != 0) void'(tx_model.pop_front());
      tick();
      n++;
    end
    tx_ready = 1'b0;
    total++;
    if (n != 16 || tx_model.size() != 0) begin
      bad++;
      $display("FAIL tx_drain_count drained=%0d required 16", n);
    end
  endtask

  task automatic test_rx();
    rx_strobe(8'h55);
    rx_strobe(8'hAA);
    axi_read(ADDR_STAT, 32'h05, "stat_rx_two", 1'b0, 8'h0);
    for (int i = 0; i < 3; i++) axi_read(ADDR_RX, rx_expect(), "rx_read", 1'b0, 8'h0);
    axi_read(ADDR_STAT, 32'h04, "stat_rx_empty", 1'b0, 8'h0);
  endtask

  task automatic test_rx_overrun();
    logic [31:0] e;
    for (int i = 0; i < 17; i++) rx_strobe(8'(i));
    axi_read(ADDR_STAT, 32'h27, "stat_overrun", 1'b0, 8'h0);
    axi_read(ADDR_STAT, 32'h07, "stat_overrun_cleared", 1'b0, 8'h0);
    e = rx_expect();
    rx_model.push_back(8'h99);
    axi_read(ADDR_RX, e, "rx_pop_with_push", 1'b1, 8'h99);
    axi_read(ADDR_STAT, 32'h07, "stat_no_overrun", 1'b0, 8'h0);
    for (int i = 0; i < 16; i++) axi_read(ADDR_RX, rx_expect(), "rx_drain", 1'b0, 8'h0);
    axi_read(ADDR_STAT, 32'h04, "stat_rx_drained", 1'b0, 8'h0);
  endtask

  task automatic test_intr_flush();
    int c;
    axi_write(ADDR_CTRL, 32'h10, 0);
    c = intr_cnt;
    rx_strobe(8'h33);
    repeat (3) tick();
    total++;
    if (intr_cnt != c + 1) begin
      bad++;
      $display("FAIL intr_rx pulses=%0d required 1", intr_cnt - c);
    end
    axi_read(ADDR_STAT, 32'h15, "stat_intr_en", 1'b0, 8'h0);
    axi_write(ADDR_TX, 32'h77, 0);
    c = intr_cnt;
    axi_write(ADDR_CTRL, 32'h13, 0);
    rx_model.delete();
    repeat (3) tick();
    total++;
    if (intr_cnt != c || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL intr_flush pulses=%0d tx_valid=%b required 0/0", intr_cnt - c, tx_valid);
    end
    axi_read(ADDR_STAT, 32'h14, "stat_flushed", 1'b0, 8'h0);
    axi_read(ADDR_RX, 32'h0, "rx_flushed", 1'b0, 8'h0);
    axi_write(ADDR_TX, 32'h66, 2);
    c = intr_cnt;
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (3) tick();
    total++;
    if (intr_cnt != c + 1 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL intr_tx_empty pulses=%0d tx_valid=%b required 1/0", intr_cnt - c, tx_valid);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    axil.araddr  = ADDR_STAT;
    axil.arvalid = 1'b1;
    n = 0;
    while (axil.arready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    axil.arvalid = 1'b0;
    total++;
    if (axil.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL mid_rvalid rvalid=%b required 1", axil.rvalid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (axil.rvalid !== 1'b0 || axil.rdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset rvalid=%b rdata=%h required 0/0", axil.rvalid, axil.rdata);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    axi_read(ADDR_STAT, 32'h04, "stat_after_mid_reset", 1'b0, 8'h0);
  endtask

  initial begin
    test_reset();
    test_tx_same_cycle();
    test_tx_full();
    test_rx();
    test_rx_overrun();
    test_intr_flush();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
